// File: rtl/ssd_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ssd_scan_driver_pkg
// Brief   : Segment codes, converter state encodings and BCD helpers.
// Revision: 1.0
// ============================================================================
package ssd_scan_driver_pkg;

    localparam int VALUE_W     = 13;
    localparam int BCD_W       = 16;
    localparam int NIBBLES     = BCD_W / 4;
    localparam int SHIFT_COUNT = VALUE_W;

    typedef logic [BCD_W-1:0]   bcd_t;
    typedef logic [VALUE_W-1:0] value_t;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Double-dabble correction applied before every shift
    function automatic bcd_t bcd_adjust(input bcd_t acc);
        bcd_t res;
        res = acc;
        for (int i = 0; i < NIBBLES; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage : ssd_scan_driver_pkg
`default_nettype wire

// File: rtl/ssd_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module  : ssd_scan_driver_if
// Brief   : Value input and display-pin bundle of the scan driver.
// Revision: 1.0
// ============================================================================
interface ssd_scan_driver_if;
    import ssd_scan_driver_pkg::*;

    value_t     value;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       busy;
    logic       bcd_valid;

    modport master (
        output value,
        input  anode,
        input  seg,
        input  busy,
        input  bcd_valid
    );

    modport slave (
        input  value,
        output anode,
        output seg,
        output busy,
        output bcd_valid
    );

endinterface : ssd_scan_driver_if
`default_nettype wire

// File: rtl/ssd_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module  : ssd_bcd_converter
// Brief   : Sequential double-dabble binary-to-BCD converter (13 -> 16 bits).
// Revision: 1.0
// ============================================================================
module ssd_bcd_converter
    import ssd_scan_driver_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire value_t value,
    output logic        busy,
    output bcd_t        bcd_out,
    output logic        bcd_done
);

    localparam logic [3:0] LAST_SHIFT = 4'(SHIFT_COUNT - 1);

    logic [1:0] state_q, state_d;
    value_t     shift_q, shift_d;
    value_t     last_q,  last_d;
    logic       force_q, force_d;
    bcd_t       acc_q,   acc_d;
    logic [3:0] cnt_q,   cnt_d;
    bcd_t       bcd_q,   bcd_d;
    bcd_t       acc_adj;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        last_d  = last_q;
        force_d = force_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        acc_adj = bcd_adjust(acc_q);

        case (state_q)
            ST_IDLE: begin
                // force_q guarantees a conversion after reset even if value is 0
                if ((value != last_q) || force_q) begin
                    shift_d = value;
                    last_d  = value;
                    force_d = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {acc_d, shift_d} = {acc_adj, shift_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_SHIFT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = acc_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            last_q  <= '0;
            force_q <= 1'b1;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            force_q <= force_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign bcd_out  = bcd_q;
    assign bcd_done = (state_q == ST_DONE);

endmodule : ssd_bcd_converter
`default_nettype wire

// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : ssd_scan_driver
// Brief   : 4-digit multiplexed seven-segment driver with BCD conversion.
// Revision: 1.0
// ============================================================================
module ssd_scan_driver
    import ssd_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV   = 17,
    parameter int BLANK_LEADING = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ssd_scan_driver_if.slave  disp
);

    logic [REFRESH_DIV-1:0] refresh_q, refresh_d;
    logic [3:0]             anode_q,   anode_d;
    logic [6:0]             seg_q,     seg_d;
    logic                   valid_q,   valid_d;

    logic [1:0] digit;
    logic [3:0] nibble;
    logic       blank;
    logic       conv_busy;
    logic       conv_done;
    bcd_t       bcd_disp;

    ssd_bcd_converter u_conv (
        .clk      (clk),
        .rst      (rst),
        .value    (disp.value),
        .busy     (conv_busy),
        .bcd_out  (bcd_disp),
        .bcd_done (conv_done)
    );

    assign digit  = refresh_q[REFRESH_DIV-1 -: 2];
    assign nibble = bcd_disp[{digit, 2'b00} +: 4];

    always_comb begin
        refresh_d = refresh_q + REFRESH_DIV'(1);
        valid_d   = valid_q | conv_done;
        // A digit is blank when it and every more significant digit are zero
        blank     = 1'b0;
        if ((BLANK_LEADING != 0) && (digit != 2'd0)) begin
            blank = ((bcd_disp >> {digit, 2'b00}) == '0);
        end
        anode_d = ~(4'b0001 << digit);
        seg_d   = blank ? SEG_BLANK : seg_encode(nibble);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_q <= '0;
            anode_q   <= 4'b1111;
            seg_q     <= SEG_BLANK;
            valid_q   <= 1'b0;
        end else begin
            refresh_q <= refresh_d;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
            valid_q   <= valid_d;
        end
    end

    assign disp.anode     = anode_q;
    assign disp.seg       = seg_q;
    assign disp.busy      = conv_busy;
    assign disp.bcd_valid = valid_q;

endmodule : ssd_scan_driver
`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_ssd_scan_driver
// Brief   : Directed self-checking bench; one DUT blanks leading zeros, one not.
// Revision: 1.0
// ============================================================================
module tb_ssd_scan_driver;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'h7F;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [6:0] cap_b [4];
    logic [6:0] cap_n [4];
    logic [6:0] exp_b [4];
    logic [6:0] exp_n [4];

    ssd_scan_driver_if ifb ();
    ssd_scan_driver_if ifn ();

    ssd_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .disp (ifb.slave)
    );

    ssd_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(0)) dut_n (
        .clk  (clk),
        .rst  (rst),
        .disp (ifn.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_value(input logic [12:0] v);
        @(negedge clk);
        ifb.value = v;
        ifn.value = v;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Records the last seg seen on each active anode over n samples
    task automatic capture(input int n);
        for (int i = 0; i < 4; i++) begin
            cap_b[i] = 7'bx;
            cap_n[i] = 7'bx;
        end
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                if (ifb.anode == ~(4'b0001 << d)) cap_b[d] = ifb.seg;
                if (ifn.anode == ~(4'b0001 << d)) cap_n[d] = ifn.seg;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        ifb.value = 13'd0;
        ifn.value = 13'd0;
        tick(2);
        n_tests++;
        if (ifb.anode !== 4'b1111) begin n_fail++; $display("FAIL reset_anode got=%b exp=1111", ifb.anode); end
        n_tests++;
        if (ifb.seg !== SB) begin n_fail++; $display("FAIL reset_seg got=%b exp=%b", ifb.seg, SB); end
        n_tests++;
        if (ifb.busy !== 1'b0 || ifb.bcd_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags busy=%b valid=%b exp=0,0", ifb.busy, ifb.bcd_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        n_tests++;
        if (ifb.busy !== 1'b1 || ifb.bcd_valid !== 1'b0) begin
            n_fail++; $display("FAIL force_start busy=%b valid=%b exp=1,0", ifb.busy, ifb.bcd_valid);
        end
        tick(13);
        n_tests++;
        if (ifb.bcd_valid !== 1'b0 || ifb.busy !== 1'b1) begin
            n_fail++; $display("FAIL edge13 busy=%b valid=%b exp=1,0", ifb.busy, ifb.bcd_valid);
        end
        tick(1);
        n_tests++;
        if (ifb.bcd_valid !== 1'b1 || ifb.busy !== 1'b0) begin
            n_fail++; $display("FAIL edge14 busy=%b valid=%b exp=0,1", ifb.busy, ifb.bcd_valid);
        end
        capture(16);
        exp_b = '{S0, SB, SB, SB};
        exp_n = '{S0, S0, S0, S0};
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (cap_b[i] !== exp_b[i]) begin n_fail++; $display("FAIL zero_scan_b d%0d got=%b exp=%b", i, cap_b[i], exp_b[i]); end
            n_tests++;
            if (cap_n[i] !== exp_n[i]) begin n_fail++; $display("FAIL zero_scan_n d%0d got=%b exp=%b", i, cap_n[i], exp_n[i]); end
        end
    endtask

    task automatic test_max;
        int busy_cnt;
        busy_cnt = 0;
        set_value(13'd8191);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (ifb.busy === 1'b1) busy_cnt++;
        end
        n_tests++;
        if (busy_cnt != 14) begin n_fail++; $display("FAIL max_busy_cycles got=%0d exp=14", busy_cnt); end
        capture(16);
        exp_b = '{S1, S9, S1, S8};
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (cap_b[i] !== exp_b[i]) begin n_fail++; $display("FAIL max_scan d%0d got=%b exp=%b", i, cap_b[i], exp_b[i]); end
        end
    endtask

    task automatic test_blank;
        set_value(13'd5);
        tick(16);
        capture(16);
        exp_b = '{S5, SB, SB, SB};
        exp_n = '{S5, S0, S0, S0};
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (cap_b[i] !== exp_b[i]) begin n_fail++; $display("FAIL blank_b d%0d got=%b exp=%b", i, cap_b[i], exp_b[i]); end
            n_tests++;
            if (cap_n[i] !== exp_n[i]) begin n_fail++; $display("FAIL blank_n d%0d got=%b exp=%b", i, cap_n[i], exp_n[i]); end
        end
    endtask

    task automatic test_back_to_back;
        set_value(13'd1234);
        tick(1);
        tick(5);
        ifb.value = 13'd42;
        ifn.value = 13'd42;
        tick(9);
        n_tests++;
        if (ifb.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_edge14_busy got=%b exp=0", ifb.busy); end
        tick(1);
        n_tests++;
        if (ifb.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy got=%b exp=1", ifb.busy); end
        capture(14);
        exp_b = '{S4, 7'b0110000, S2, S1};
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (cap_b[i] !== exp_b[i]) begin n_fail++; $display("FAIL b2b_1234 d%0d got=%b exp=%b", i, cap_b[i], exp_b[i]); end
        end
        n_tests++;
        if (ifb.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_edge29_busy got=%b exp=0", ifb.busy); end
        capture(16);
        exp_b = '{S2, S4, SB, SB};
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (cap_b[i] !== exp_b[i]) begin n_fail++; $display("FAIL b2b_42 d%0d got=%b exp=%b", i, cap_b[i], exp_b[i]); end
        end
    endtask

    task automatic test_reset_mid;
        set_value(13'd4000);
        tick(6);
        #3;
        rst = 1'b0;
        #1;
        n_tests++;
        if (ifb.anode !== 4'b1111 || ifb.seg !== SB) begin
            n_fail++; $display("FAIL async_rst_outputs anode=%b seg=%b exp=1111,1111111", ifb.anode, ifb.seg);
        end
        n_tests++;
        if (ifb.busy !== 1'b0 || ifb.bcd_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_rst_flags busy=%b valid=%b exp=0,0", ifb.busy, ifb.bcd_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick(14);
        n_tests++;
        if (ifb.bcd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_edge13 valid got=%b exp=0", ifb.bcd_valid); end
        tick(1);
        n_tests++;
        if (ifb.bcd_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_edge14 valid got=%b exp=1", ifb.bcd_valid); end
        capture(16);
        exp_b = '{S0, S0, S0, S4};
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (cap_b[i] !== exp_b[i]) begin n_fail++; $display("FAIL rst_mid_4000 d%0d got=%b exp=%b", i, cap_b[i], exp_b[i]); end
        end
    endtask

    task automatic test_refresh_wrap;
        logic [3:0] exp_anode;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 24; k++) begin
            tick(1);
            exp_anode = ~(4'b0001 << ((k % 16) / 4));
            n_tests++;
            if (ifb.anode !== exp_anode) begin
                n_fail++; $display("FAIL wrap_anode k=%0d got=%b exp=%b", k, ifb.anode, exp_anode);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_max();
        test_blank();
        test_back_to_back();
        test_reset_mid();
        test_refresh_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ssd_scan_driver
`default_nettype wire

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Consumes the 13-bit `ssd` debug word that the datapath drives for FPGA display, and physically drives a 4-digit multiplexed seven-segment display.
- A sequential double-dabble converter turns the binary value into BCD.
- A refresh counter scans the anodes, one digit at a time.
- Sits at the FPGA top level, between the datapath `ssd` output and the board display pins.

Parameters:
- REFRESH_DIV, 17, width of the refresh counter; the digit index is counter[REFRESH_DIV-1:REFRESH_DIV-2], so each digit is lit for 2^(REFRESH_DIV-2) clocks.
- BLANK_LEADING, 1, 1 = blank leading-zero digits; digit 0 is never blanked.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- value  input  13  unsigned binary value to display (0..8191).
- anode  output  4  digit enables, active-low one-hot; anode[0] = ones (rightmost) digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- busy  output  1  high while a BCD conversion is in progress.
- bcd_valid  output  1  high once at least one conversion has completed since reset.

Behaviour:
- Reset (rst=0, async) sets:
  - anode=4'b1111, seg=7'h7F, busy=0, bcd_valid=0.
  - refresh counter=0, displayed BCD=0.
  - FSM=IDLE with force flag=1.
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: at an edge where (value != last_value) or force=1:
    - shift reg <= value; last_value <= value; force <= 0.
    - BCD accumulator <= 0; bit count <= 0; go to SHIFT.
  - SHIFT: each edge, every BCD nibble >= 5 gets +3, then {bcd,shift} is shifted left by 1 and count increments. After the 13th shift (count==12 at the edge), go to DONE.
  - DONE: displayed BCD <= accumulator; bcd_valid <= 1; go to IDLE.
- Latency: value captured at edge 0, shifts at edges 1..13, display BCD updated at edge 14.
  - busy = (state != IDLE); it is high from after edge 0 until after edge 14.
- value changes while busy are ignored. On return to IDLE the comparison with last_value restarts a conversion at the next edge, so the final displayed value always matches the stable input.
- BCD width is 16 bits (4 nibbles). 8191 is the maximum, so there is no overflow. The thousands nibble never exceeds 8.
- Refresh counter:
  - Increments every clock and wraps at 2^REFRESH_DIV - 1 -> 0.
  - Digit index d = top 2 bits; order 0,1,2,3,0...
- Outputs are registered, so anode/seg reflect index d one clock after the counter shows d.
  - anode = ~(4'b0001 << d).
  - seg = encoding of the displayed nibble d.
- Blanking: if BLANK_LEADING=1 and d>0 and all nibbles at positions >= d are zero, then seg=7'h7F (anode still active).
- Segment codes (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibbles >9 are unreachable; map them to 7'h7F.
- Scan and conversion are independent; the display shows the old BCD until DONE.
- Reset mid-conversion: the conversion is abandoned, all state is reset, and force=1 causes a fresh conversion of the current value after release.

Decomposition:
- Shared package:
  - segment-code constants SEG_0..SEG_9 and SEG_BLANK.
  - FSM state encodings.
  - BCD width constant (16).
- One sub-module, ssd_bcd_converter, contains the IDLE/SHIFT/DONE FSM with ports:
  - clk, rst, value, busy, bcd_out[15:0], bcd_done.
- The parent holds the refresh counter, blanking logic and segment decode.

Test Plan:
- Reset release with value=0, REFRESH_DIV=4 -> conversion runs despite no change; bcd_valid rises after edge 14; scan shows seg=1000000 on anode 1110 and 7'h7F on anodes 1101/1011/0111.
- value=8191 -> busy high for 14 cycles; BCD=16'h8191; anodes 1110/1101/1011/0111 show 1111001/0010000/1111001/0000000.
- value=5, BLANK_LEADING=1 -> digit0 = 0010010, digits 1-3 blank; with BLANK_LEADING=0 digits 1-3 = 1000000.
- value=1234, then 42 at edge 5 of the conversion -> display shows 1234 at edge 14; a new conversion starts at edge 15; display shows "  42" at edge 29.
- Assert rst=0 asynchronously during SHIFT (value=4000) -> anode=1111 and seg=7F immediately, busy=0; after release, 4000 is displayed 15 edges later.
- Refresh wrap: run 2^REFRESH_DIV+8 cycles -> the anode sequence repeats 1110,1101,1011,0111, with each digit held 4 clocks (REFRESH_DIV=4).
